// File: rtl/uart_pkg.sv
// Purpose: shared types and frame constants for the 8N1 UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam int   BIT_CNT_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO; pop_data always shows the oldest entry.
// Latency: a push is visible on pop_data/empty/count the edge after it is accepted.
// Backpressure: push while full (without pop) is ignored; pop while empty is ignored.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (empties the FIFO)
//   push, push_data      write strobe and data
//   pop                  advance the head on the next edge
//   pop_data             head entry, forced to 0 while empty
//   empty, full, count   occupancy status
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty = (count == '0);
    assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));

    // A push into a full FIFO is allowed when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Show zero while empty so the head reads as a defined value straight out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: 8N1 UART receiver with bit-centre sampling, stop-bit check and a show-ahead byte FIFO.
// Latency: a good byte reaches rd_data/empty/count on the edge after its stop-bit sample.
// Backpressure: none on the line; a byte arriving with the FIFO full and no pop is dropped and flags ovf.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rxd              asynchronous serial input, idle high
//   rd_en            pop request (ignored while empty)
//   rd_data, empty, full, count   FIFO head and occupancy
//   ferr, ovf        sticky framing-error / overflow flags
//   clr_err          clears both flags on the next edge (a same-cycle set wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rxd,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       ferr,
    output logic                       ovf,
    input  logic                       clr_err
);

    localparam int TIMER_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [TIMER_W-1:0]   HALF_M1  = TIMER_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [TIMER_W-1:0]   BIT_M1   = TIMER_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   rx_meta;
    logic                   rxs;
    logic [TIMER_W-1:0]     timer;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   tick;
    logic                   stop_tick;
    logic                   pop_ok;
    logic                   push;
    logic                   set_ferr;
    logic                   set_ovf;

    // Two-flop synchronizer; reset high so the idle line never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign tick = (timer == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rxs) state_nxt = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (tick) state_nxt = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (tick && bit_cnt == LAST_BIT) state_nxt = STOP;
            end
            STOP: begin
                // Leaving at mid stop bit keeps a back-to-back start edge catchable.
                if (tick) state_nxt = (rxs == STOP_LEVEL) ? IDLE : BREAK;
            end
            BREAK: begin
                // Wait out a held-low line instead of decoding it as 0x00 bytes.
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: decisions taken at the stop-bit sample.
    always_comb begin
        stop_tick = (state == STOP) && tick;
        pop_ok    = rd_en & ~empty;
        push      = stop_tick && (rxs == STOP_LEVEL) && (!full || pop_ok);
        set_ovf   = stop_tick && (rxs == STOP_LEVEL) && full && !pop_ok;
        set_ferr  = stop_tick && (rxs != STOP_LEVEL);
    end

    // Bit timer, bit counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) timer <= HALF_M1;
                end
                START: begin
                    if (!tick) begin
                        timer <= timer - 1'b1;
                    end else if (!rxs) begin
                        timer   <= BIT_M1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        timer   <= BIT_M1;
                    end
                end
                STOP: begin
                    if (!tick) timer <= timer - 1'b1;
                end
                default: timer <= '0;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (set_ferr)     ferr <= 1'b1;
            else if (clr_err) ferr <= 1'b0;
            if (set_ovf)      ovf  <= 1'b1;
            else if (clr_err) ovf  <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed self-checking bench for uart_rx_fifo with a short bit period.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int HALF = 4;
    localparam int BIT  = 2 * HALF;
    localparam int LOG2 = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            rxd;
    logic            rd_en;
    logic            clr_err;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [LOG2:0]   count;
    logic            ferr;
    logic            ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_PER_HALF_BIT (HALF),
        .FIFO_DEPTH_LOG2  (LOG2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ferr    (ferr),
        .ovf     (ovf),
        .clr_err (clr_err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB-first, then the stop level held for stop_cyc cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_cyc);
        rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(BIT);
        end
        rxd = stop_lvl;
        tick(stop_cyc);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"}, rd_data, 8'h00);
        check({tag, "_empty"},   empty,   1'b1);
        check({tag, "_full"},    full,    1'b0);
        check({tag, "_count"},   count,   5'd0);
        check({tag, "_ferr"},    ferr,    1'b0);
        check({tag, "_ovf"},     ovf,     1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        check_reset_values("reset");

        // 1: single good byte, exact push latency.
        send_frame(8'h55, 1'b1, BIT - 2);
        check("t1_empty_before", empty, 1'b1);
        tick(1);
        check("t1_empty_after", empty, 1'b0);
        check("t1_rd_data", rd_data, 8'h55);
        check("t1_count", count, 5'd1);
        check("t1_ferr", ferr, 1'b0);
        tick(1);
        pop_expect("t1_pop", 8'h55);
        check("t1_empty_pop", empty, 1'b1);
        check("t1_count_pop", count, 5'd0);
        tick(8);

        // 2: three back-to-back frames.
        send_frame(8'hA3, 1'b1, BIT);
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        check("t2_count", count, 5'd3);
        pop_expect("t2_pop0", 8'hA3);
        pop_expect("t2_pop1", 8'h00);
        pop_expect("t2_pop2", 8'hFF);
        check("t2_empty", empty, 1'b1);

        // 3: short low glitch.
        tick(4);
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(5);
        check("t3_state_idle", dut.state, IDLE);
        tick(40);
        check("t3_empty", empty, 1'b1);
        send_frame(8'h5A, 1'b1, BIT);
        check("t3_count_after", count, 5'd1);
        pop_expect("t3_pop", 8'h5A);

        // 4: framing error followed by break, then a good byte.
        send_frame(8'h3C, 1'b0, BIT);
        tick(100);
        check("t4_ferr", ferr, 1'b1);
        check("t4_empty", empty, 1'b1);
        rxd = 1'b1;
        tick(16);
        send_frame(8'h11, 1'b1, BIT);
        check("t4_count", count, 5'd1);
        check("t4_rd_data", rd_data, 8'h11);
        check("t4_ferr_sticky", ferr, 1'b1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t4_ferr_clr", ferr, 1'b0);
        pop_expect("t4_pop", 8'h11);
        check("t4_empty_pop", empty, 1'b1);

        // 5a: overflow on the 17th byte.
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, BIT);
        end
        check("t5_full", full, 1'b1);
        check("t5_count", count, 5'd16);
        check("t5_ovf", ovf, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pop_expect("t5_pop", 8'(i));
        end
        check("t5_empty", empty, 1'b1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t5_ovf_clr", ovf, 1'b0);

        // 5b: pop in the stop-sample cycle of byte 17 makes room for it.
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 1'b1, BIT);
        end
        check("t5b_full_pre", full, 1'b1);
        send_frame(8'h10, 1'b1, BIT - 2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("t5b_ovf", ovf, 1'b0);
        check("t5b_count", count, 5'd16);
        check("t5b_full", full, 1'b1);
        tick(1);
        for (int i = 1; i <= 16; i++) begin
            pop_expect("t5b_pop", 8'(i));
        end
        check("t5b_empty", empty, 1'b1);

        // 6: reset in the middle of a frame.
        send_frame(8'h42, 1'b1, BIT);
        check("t6_count_pre", count, 5'd1);
        rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 3; i++) begin
            rxd = (8'h77 >> i) & 8'h01;
            tick(BIT);
        end
        rst = 1'b1;
        rxd = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_reset_values("t6_rst");
        tick(8);
        send_frame(8'h88, 1'b1, BIT);
        check("t6_count", count, 5'd1);
        pop_expect("t6_pop", 8'h88);
        check("t6_empty", empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
